// File: rtl/axi_mem_responder_if.sv
// AXI4+ATOP bus bundle seen by the memory responder.
// Lock signals exist only when AXI_MEM_EXCL_EN is defined.
interface axi_mem_responder_if #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
);
  logic                   aw_valid_i;
  logic                   aw_ready_o;
  logic [IdWidth-1:0]     aw_id_i;
  logic [AddrWidth-1:0]   aw_addr_i;
  logic [7:0]             aw_len_i;
  logic [1:0]             aw_burst_i;
  logic [5:0]             aw_atop_i;
  logic                   w_valid_i;
  logic                   w_ready_o;
  logic [DataWidth-1:0]   w_data_i;
  logic [DataWidth/8-1:0] w_strb_i;
  logic                   w_last_i;
  logic                   b_valid_o;
  logic                   b_ready_i;
  logic [IdWidth-1:0]     b_id_o;
  logic [1:0]             b_resp_o;
  logic                   ar_valid_i;
  logic                   ar_ready_o;
  logic [IdWidth-1:0]     ar_id_i;
  logic [AddrWidth-1:0]   ar_addr_i;
  logic [7:0]             ar_len_i;
  logic [1:0]             ar_burst_i;
  logic                   r_valid_o;
  logic                   r_ready_i;
  logic [IdWidth-1:0]     r_id_o;
  logic [DataWidth-1:0]   r_data_o;
  logic [1:0]             r_resp_o;
  logic                   r_last_o;
`ifdef AXI_MEM_EXCL_EN
  logic                   aw_lock_i;
  logic                   ar_lock_i;
`endif

  modport slave (
`ifdef AXI_MEM_EXCL_EN
    input  aw_lock_i, ar_lock_i,
`endif
    input  aw_valid_i, aw_id_i, aw_addr_i,
    input  aw_len_i, aw_burst_i, aw_atop_i,
    output aw_ready_o,
    input  w_valid_i, w_data_i, w_strb_i, w_last_i,
    output w_ready_o,
    output b_valid_o, b_id_o, b_resp_o,
    input  b_ready_i,
    input  ar_valid_i, ar_id_i, ar_addr_i,
    input  ar_len_i, ar_burst_i,
    output ar_ready_o,
    output r_valid_o, r_id_o, r_data_o,
    output r_resp_o, r_last_o,
    input  r_ready_i
  );

  modport master (
`ifdef AXI_MEM_EXCL_EN
    output aw_lock_i, ar_lock_i,
`endif
    output aw_valid_i, aw_id_i, aw_addr_i,
    output aw_len_i, aw_burst_i, aw_atop_i,
    input  aw_ready_o,
    output w_valid_i, w_data_i, w_strb_i, w_last_i,
    input  w_ready_o,
    input  b_valid_o, b_id_o, b_resp_o,
    output b_ready_i,
    output ar_valid_i, ar_id_i, ar_addr_i,
    output ar_len_i, ar_burst_i,
    input  ar_ready_o,
    input  r_valid_o, r_id_o, r_data_o,
    input  r_resp_o, r_last_o,
    output r_ready_i
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate with internal SRAM, one transaction at a time.
// Define AXI_MEM_EXCL_EN for the single-entry exclusive monitor.
module axi_mem_responder #(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MemWords  = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  axi_mem_responder_if.slave bus
);
  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned IdxW  = $clog2(MemWords);
  localparam int unsigned TopB  = IdxW + OffW;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic       RrWrite    = 1'b0;
  localparam logic       RrRead     = 1'b1;

  typedef enum logic [1:0] {
    IDLE, WDATA, WRESP, RDATA
  } state_e;

  logic [DataWidth-1:0] mem_q [MemWords];

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [1:0]           burst_q, burst_d;
  logic [1:0]           resp_q, resp_d;
  logic                 wen_q, wen_d;
  logic                 r_valid_q, r_valid_d;
  logic                 r_last_q, r_last_d;
  logic [DataWidth-1:0] r_data_q, r_data_d;

  logic [IdxW-1:0] aw_idx, ar_idx, idx_nxt;
  logic            aw_oor, ar_oor;
  logic [1:0]      aw_err, ar_err;
  logic            grant_w, grant_r, mem_we;
  logic            unused_ok;

  // Byte-offset bits are ignored: every beat is full width.
  assign aw_idx = bus.aw_addr_i[TopB-1:OffW];
  assign ar_idx = bus.ar_addr_i[TopB-1:OffW];
  assign aw_oor = |bus.aw_addr_i[AddrWidth-1:TopB];
  assign ar_oor = |bus.ar_addr_i[AddrWidth-1:TopB];
  assign unused_ok = ^{bus.aw_addr_i[OffW-1:0],
                       bus.ar_addr_i[OffW-1:0]};

  assign aw_err = aw_oor ? RespDecErr :
                  (bus.aw_burst_i == BurstWrap ||
                   bus.aw_atop_i != 6'd0) ? RespSlvErr :
                  RespOkay;
  assign ar_err = ar_oor ? RespDecErr :
                  (bus.ar_burst_i == BurstWrap) ? RespSlvErr :
                  RespOkay;

  assign idx_nxt = (burst_q == BurstIncr) ?
                   idx_q + IdxW'(1) : idx_q;

  // On simultaneous requests, favour the channel not served last.
  assign grant_w = (state_q == IDLE) && bus.aw_valid_i &&
                   (!bus.ar_valid_i || rr_q == RrRead);
  assign grant_r = (state_q == IDLE) && bus.ar_valid_i &&
                   !grant_w;

`ifdef AXI_MEM_EXCL_EN
  logic               rsv_v_q, rsv_v_d;
  logic [IdWidth-1:0] rsv_id_q, rsv_id_d;
  logic [IdxW-1:0]    rsv_idx_q, rsv_idx_d;
  logic               rsv_hit;

  assign rsv_hit = rsv_v_q &&
                   rsv_id_q == bus.aw_id_i &&
                   rsv_idx_q == aw_idx;
`endif

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    burst_d   = burst_q;
    resp_d    = resp_q;
    wen_d     = wen_q;
    r_valid_d = r_valid_q;
    r_last_d  = r_last_q;
    r_data_d  = r_data_q;
    mem_we    = 1'b0;
`ifdef AXI_MEM_EXCL_EN
    rsv_v_d   = rsv_v_q;
    rsv_id_d  = rsv_id_q;
    rsv_idx_d = rsv_idx_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_w) begin
          id_d    = bus.aw_id_i;
          idx_d   = aw_idx;
          len_d   = bus.aw_len_i;
          burst_d = bus.aw_burst_i;
          cnt_d   = 8'd0;
          resp_d  = aw_err;
          wen_d   = (aw_err == RespOkay);
          rr_d    = RrWrite;
          state_d = WDATA;
`ifdef AXI_MEM_EXCL_EN
          if (bus.aw_lock_i && aw_err == RespOkay) begin
            if (rsv_hit) begin
              resp_d  = RespExOkay;
              rsv_v_d = 1'b0;
            end else begin
              wen_d = 1'b0;
            end
          end
`endif
        end else if (grant_r) begin
          id_d      = bus.ar_id_i;
          idx_d     = ar_idx;
          len_d     = bus.ar_len_i;
          burst_d   = bus.ar_burst_i;
          cnt_d     = 8'd0;
          resp_d    = ar_err;
          rr_d      = RrRead;
          r_valid_d = 1'b1;
          r_last_d  = (bus.ar_len_i == 8'd0);
          r_data_d  = (ar_err == RespOkay) ?
                      mem_q[ar_idx] : '0;
          state_d   = RDATA;
`ifdef AXI_MEM_EXCL_EN
          if (bus.ar_lock_i && ar_err == RespOkay) begin
            resp_d    = RespExOkay;
            rsv_v_d   = 1'b1;
            rsv_id_d  = bus.ar_id_i;
            rsv_idx_d = ar_idx;
          end
`endif
        end
      end
      WDATA: begin
        if (bus.w_valid_i) begin
          mem_we = wen_q;
          cnt_d  = cnt_q + 8'd1;
          idx_d  = idx_nxt;
`ifdef AXI_MEM_EXCL_EN
          if (wen_q && rsv_v_q && rsv_idx_q == idx_q)
            rsv_v_d = 1'b0;
`endif
          // Short or long bursts end on w_last; keep the data.
          if (bus.w_last_i) begin
            if (cnt_q != len_q && !resp_q[1])
              resp_d = RespSlvErr;
            state_d = WRESP;
          end
        end
      end
      WRESP: begin
        if (bus.b_ready_i)
          state_d = IDLE;
      end
      RDATA: begin
        if (bus.r_ready_i) begin
          if (r_last_q) begin
            r_valid_d = 1'b0;
            r_last_d  = 1'b0;
            state_d   = IDLE;
          end else begin
            cnt_d    = cnt_q + 8'd1;
            idx_d    = idx_nxt;
            r_last_d = (cnt_q + 8'd1 == len_q);
            r_data_d = resp_q[1] ? '0 : mem_q[idx_nxt];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_q      <= RrRead;
      id_q      <= '0;
      idx_q     <= '0;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      burst_q   <= 2'b00;
      resp_q    <= RespOkay;
      wen_q     <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      burst_q   <= burst_d;
      resp_q    <= resp_d;
      wen_q     <= wen_d;
      r_valid_q <= r_valid_d;
      r_last_q  <= r_last_d;
      r_data_q  <= r_data_d;
    end
  end

`ifdef AXI_MEM_EXCL_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv_v_q   <= 1'b0;
      rsv_id_q  <= '0;
      rsv_idx_q <= '0;
    end else begin
      rsv_v_q   <= rsv_v_d;
      rsv_id_q  <= rsv_id_d;
      rsv_idx_q <= rsv_idx_d;
    end
  end
`endif

  // SRAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (bus.w_strb_i[b])
          mem_q[idx_q][8*b +: 8] <= bus.w_data_i[8*b +: 8];
      end
    end
  end

  assign bus.aw_ready_o = rst_ni && grant_w;
  assign bus.ar_ready_o = rst_ni && grant_r;
  assign bus.w_ready_o  = rst_ni && (state_q == WDATA);
  assign bus.b_valid_o  = (state_q == WRESP);
  assign bus.b_id_o     = id_q;
  assign bus.b_resp_o   = resp_q;
  assign bus.r_valid_o  = r_valid_q;
  assign bus.r_id_o     = id_q;
  assign bus.r_data_o   = r_data_q;
  assign bus.r_resp_o   = resp_q;
  assign bus.r_last_o   = r_last_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed checks of axi_mem_responder.
// Define AXI_MEM_EXCL_EN to also exercise the exclusive monitor.
module tb_axi_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   fails = 0;

  logic [63:0] wq [4];
  logic [63:0] rq [4];

  localparam logic [63:0] DA = 64'hA0A1A2A3A4A5A6A7;
  localparam logic [63:0] DB = 64'hB0B1B2B3B4B5B6B7;
  localparam logic [63:0] DC = 64'hC0C1C2C3C4C5C6C7;
  localparam logic [63:0] DD = 64'hD0D1D2D3D4D5D6D7;
  localparam logic [1:0]  OK = 2'b00;
  localparam logic [1:0]  EX = 2'b01;
  localparam logic [1:0]  SE = 2'b10;
  localparam logic [1:0]  DE = 2'b11;
  localparam logic [1:0]  FIX = 2'b00;
  localparam logic [1:0]  INC = 2'b01;
  localparam logic [1:0]  WRP = 2'b10;

  always #5 clk = ~clk;

  axi_mem_responder_if #(
    .IdWidth(4), .AddrWidth(64), .DataWidth(64)
  ) bus ();

  axi_mem_responder #(
    .IdWidth(4), .AddrWidth(64),
    .DataWidth(64), .MemWords(1024)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic aw(input logic [3:0] id,
                    input logic [63:0] a,
                    input logic [7:0] l,
                    input logic [1:0] bt,
                    input logic [5:0] at);
    bus.aw_id_i    = id;
    bus.aw_addr_i  = a;
    bus.aw_len_i   = l;
    bus.aw_burst_i = bt;
    bus.aw_atop_i  = at;
    bus.aw_valid_i = 1'b1;
    #1 chk("aw_ready", 64'(bus.aw_ready_o), 64'd1);
    @(posedge clk); @(negedge clk);
    bus.aw_valid_i = 1'b0;
  endtask

  task automatic ar(input logic [3:0] id,
                    input logic [63:0] a,
                    input logic [7:0] l,
                    input logic [1:0] bt);
    bus.ar_id_i    = id;
    bus.ar_addr_i  = a;
    bus.ar_len_i   = l;
    bus.ar_burst_i = bt;
    bus.ar_valid_i = 1'b1;
    #1 chk("ar_ready", 64'(bus.ar_ready_o), 64'd1);
    @(posedge clk); @(negedge clk);
    bus.ar_valid_i = 1'b0;
  endtask

  task automatic w(input logic [63:0] d,
                   input logic [7:0] s,
                   input logic lst);
    bus.w_data_i  = d;
    bus.w_strb_i  = s;
    bus.w_last_i  = lst;
    bus.w_valid_i = 1'b1;
    #1 chk("w_ready", 64'(bus.w_ready_o), 64'd1);
    @(posedge clk); @(negedge clk);
    bus.w_valid_i = 1'b0;
    bus.w_last_i  = 1'b0;
  endtask

  task automatic b(input logic [3:0] id,
                   input logic [1:0] rs);
    bus.b_ready_i = 1'b1;
    #1;
    chk("b_valid", 64'(bus.b_valid_o), 64'd1);
    chk("b_id", 64'(bus.b_id_o), 64'(id));
    chk("b_resp", 64'(bus.b_resp_o), 64'(rs));
    @(posedge clk); @(negedge clk);
    bus.b_ready_i = 1'b0;
    #1 chk("b_done", 64'(bus.b_valid_o), 64'd0);
  endtask

  task automatic wr(input logic [3:0] id,
                    input logic [63:0] a,
                    input logic [7:0] l,
                    input logic [1:0] bt,
                    input logic [5:0] at,
                    input logic [7:0] s,
                    input logic [1:0] rs);
    aw(id, a, l, bt, at);
    for (int i = 0; i <= int'(l); i++)
      w(wq[i], s, i == int'(l));
    b(id, rs);
  endtask

  // r_valid must hold every cycle: no bubbles at full rate.
  task automatic rbeats(input logic [3:0] id,
                        input logic [7:0] l,
                        input logic [1:0] rs);
    bus.r_ready_i = 1'b1;
    for (int i = 0; i <= int'(l); i++) begin
      #1;
      chk("r_valid", 64'(bus.r_valid_o), 64'd1);
      chk("r_data", bus.r_data_o, rq[i]);
      chk("r_resp", 64'(bus.r_resp_o), 64'(rs));
      chk("r_last", 64'(bus.r_last_o),
          64'(i == int'(l)));
      chk("r_id", 64'(bus.r_id_o), 64'(id));
      @(posedge clk); @(negedge clk);
    end
    bus.r_ready_i = 1'b0;
    #1 chk("r_done", 64'(bus.r_valid_o), 64'd0);
  endtask

  task automatic rd(input logic [3:0] id,
                    input logic [63:0] a,
                    input logic [7:0] l,
                    input logic [1:0] bt,
                    input logic [1:0] rs);
    ar(id, a, l, bt);
    rbeats(id, l, rs);
  endtask

  task automatic arb(input logic expw,
                     input logic [3:0] wid,
                     input logic [63:0] wa,
                     input logic [3:0] rid,
                     input logic [63:0] ra);
    bus.aw_id_i    = wid;
    bus.aw_addr_i  = wa;
    bus.aw_len_i   = 8'd0;
    bus.aw_burst_i = INC;
    bus.aw_atop_i  = 6'd0;
    bus.ar_id_i    = rid;
    bus.ar_addr_i  = ra;
    bus.ar_len_i   = 8'd0;
    bus.ar_burst_i = INC;
    bus.aw_valid_i = 1'b1;
    bus.ar_valid_i = 1'b1;
    #1;
    chk("arb_aw", 64'(bus.aw_ready_o), 64'(expw));
    chk("arb_ar", 64'(bus.ar_ready_o), 64'(!expw));
    if (expw) bus.ar_valid_i = 1'b0;
    else      bus.aw_valid_i = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.aw_valid_i = 1'b0;
    bus.ar_valid_i = 1'b0;
  endtask

  initial begin
    bus.aw_valid_i = 1'b0;
    bus.aw_id_i    = '0;
    bus.aw_addr_i  = '0;
    bus.aw_len_i   = '0;
    bus.aw_burst_i = '0;
    bus.aw_atop_i  = '0;
    bus.w_valid_i  = 1'b0;
    bus.w_data_i   = '0;
    bus.w_strb_i   = '0;
    bus.w_last_i   = 1'b0;
    bus.b_ready_i  = 1'b0;
    bus.ar_valid_i = 1'b0;
    bus.ar_id_i    = '0;
    bus.ar_addr_i  = '0;
    bus.ar_len_i   = '0;
    bus.ar_burst_i = '0;
    bus.r_ready_i  = 1'b0;
`ifdef AXI_MEM_EXCL_EN
    bus.aw_lock_i  = 1'b0;
    bus.ar_lock_i  = 1'b0;
`endif
    wq = '{DA, DB, DC, DD};
    rq = '{DA, DB, DC, DD};

    repeat (2) @(negedge clk);
    bus.aw_valid_i = 1'b1;
    #1;
    chk("rst_aw_ready", 64'(bus.aw_ready_o), 64'd0);
    chk("rst_w_ready", 64'(bus.w_ready_o), 64'd0);
    chk("rst_b_valid", 64'(bus.b_valid_o), 64'd0);
    chk("rst_r_valid", 64'(bus.r_valid_o), 64'd0);
    chk("rst_r_last", 64'(bus.r_last_o), 64'd0);
    chk("rst_r_data", bus.r_data_o, 64'd0);
    chk("rst_b_id", 64'(bus.b_id_o), 64'd0);
    chk("rst_r_resp", 64'(bus.r_resp_o), 64'd0);
    bus.aw_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // INCR burst write then read back
    wq = '{DA, DB, DC, DD};
    wr(4'd3, 64'h10, 8'd3, INC, 6'd0, 8'hFF, OK);
    rq = '{DA, DB, DC, DD};
    rd(4'd3, 64'h10, 8'd3, INC, OK);

    // partial strobe over all-ones word
    wq[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    wr(4'd1, 64'h0, 8'd0, INC, 6'd0, 8'hFF, OK);
    wq[0] = 64'h1122334455667788;
    wr(4'd1, 64'h0, 8'd0, INC, 6'd0, 8'h0F, OK);
    rq[0] = 64'hFFFFFFFF55667788;
    rd(4'd1, 64'h0, 8'd0, INC, OK);

    // out of range: DECERR, zero data, no aliasing
    rq[0] = 64'd0;
    rq[1] = 64'd0;
    rd(4'd2, 64'h2000, 8'd1, INC, DE);
    wq[0] = 64'h5A5A5A5A5A5A5A5A;
    wr(4'd2, 64'h2000, 8'd0, INC, 6'd0, 8'hFF, DE);
    rq[0] = 64'hFFFFFFFF55667788;
    rd(4'd2, 64'h0, 8'd0, INC, OK);

    // atomics and WRAP are rejected
    wq[0] = 64'h0123456789ABCDEF;
    wr(4'd4, 64'h10, 8'd0, INC, 6'h20, 8'hFF, SE);
    rq[0] = DA;
    rd(4'd4, 64'h10, 8'd0, INC, OK);
    rq[0] = 64'd0;
    rq[1] = 64'd0;
    rd(4'd4, 64'h10, 8'd1, WRP, SE);

    // FIXED bursts keep hitting one word
    wq[0] = 64'hE0; wq[1] = 64'hE1; wq[2] = 64'hE2;
    wr(4'd5, 64'h30, 8'd2, FIX, 6'd0, 8'hFF, OK);
    rq[0] = 64'hE2; rq[1] = 64'hE2;
    rd(4'd5, 64'h30, 8'd1, FIX, OK);

    // short burst: SLVERR, data still written
    aw(4'd6, 64'h50, 8'd2, INC, 6'd0);
    w(64'h1111, 8'hFF, 1'b0);
    w(64'h2222, 8'hFF, 1'b1);
    b(4'd6, SE);
    rq[0] = 64'h1111; rq[1] = 64'h2222;
    rd(4'd6, 64'h50, 8'd1, INC, OK);

    // round-robin after a read: W, R, W
    arb(1'b1, 4'd7, 64'h60, 4'd8, 64'h10);
    w(64'h6060, 8'hFF, 1'b1);
    b(4'd7, OK);
    arb(1'b0, 4'd7, 64'h68, 4'd8, 64'h10);
    rq[0] = DA;
    rbeats(4'd8, 8'd0, OK);
    arb(1'b1, 4'd7, 64'h68, 4'd8, 64'h10);
    w(64'h6868, 8'hFF, 1'b1);
    b(4'd7, OK);
    rq[0] = 64'h6060; rq[1] = 64'h6868;
    rd(4'd9, 64'h60, 8'd1, INC, OK);

    // back-pressure: R beat held stable
    ar(4'd10, 64'h10, 8'd1, INC);
    bus.r_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", 64'(bus.r_valid_o), 64'd1);
      chk("stall_data", bus.r_data_o, DA);
      chk("stall_last", 64'(bus.r_last_o), 64'd0);
      @(negedge clk);
    end
    rq[0] = DA; rq[1] = DB;
    rbeats(4'd10, 8'd1, OK);

    // async reset in the middle of a read burst
    ar(4'd11, 64'h10, 8'd3, INC);
    bus.r_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.aw_valid_i = 1'b1;
    bus.ar_valid_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_r_valid", 64'(bus.r_valid_o), 64'd0);
    chk("mid_r_last", 64'(bus.r_last_o), 64'd0);
    chk("mid_r_data", bus.r_data_o, 64'd0);
    chk("mid_b_valid", 64'(bus.b_valid_o), 64'd0);
    chk("mid_aw_ready", 64'(bus.aw_ready_o), 64'd0);
    chk("mid_ar_ready", 64'(bus.ar_ready_o), 64'd0);
    chk("mid_w_ready", 64'(bus.w_ready_o), 64'd0);
    bus.aw_valid_i = 1'b0;
    bus.ar_valid_i = 1'b0;
    bus.r_ready_i  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rq[0] = DA;
    rd(4'd11, 64'h10, 8'd0, INC, OK);

`ifdef AXI_MEM_EXCL_EN
    wq[0] = 64'h4040;
    wr(4'd1, 64'h40, 8'd0, INC, 6'd0, 8'hFF, OK);
    bus.ar_lock_i = 1'b1;
    rq[0] = 64'h4040;
    rd(4'd1, 64'h40, 8'd0, INC, EX);
    bus.ar_lock_i = 1'b0;
    bus.aw_lock_i = 1'b1;
    wq[0] = 64'h4141;
    wr(4'd1, 64'h40, 8'd0, INC, 6'd0, 8'hFF, EX);
    wq[0] = 64'h4242;
    wr(4'd1, 64'h40, 8'd0, INC, 6'd0, 8'hFF, OK);
    bus.aw_lock_i = 1'b0;
    rq[0] = 64'h4141;
    rd(4'd1, 64'h40, 8'd0, INC, OK);
`else
    chk("no_exokay", 64'(EX), 64'(bus.b_resp_o) + 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, fails);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview: AXI4 subordinate with internal SRAM. It terminates the 64-bit AXI4+ATOP bus that the cv32a65x core drives as initiator (ID 4b, addr 64b, data 64b). Used as a simulation and FPGA boot/scratch memory behind the core's NoC port. Serves one transaction at a time, with INCR/FIXED bursts and beat-by-beat handshakes.

Parameters:
IdWidth, 4, AXI ID width
AddrWidth, 64, AXI address width
DataWidth, 64, AXI data width; beat = DataWidth/8 bytes
MemWords, 1024, SRAM depth in DataWidth words (power of 2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
aw_valid_i  in  1  write address valid
aw_ready_o  out  1  write address ready
aw_id_i  in  IdWidth  write ID
aw_addr_i  in  AddrWidth  write start byte address
aw_len_i  in  8  beats-1
aw_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP
aw_atop_i  in  6  atomic op; nonzero unsupported
w_valid_i  in  1  write data valid
w_ready_o  out  1  write data ready
w_data_i  in  DataWidth  write data
w_strb_i  in  DataWidth/8  byte enables
w_last_i  in  1  last write beat
b_valid_o  out  1  write response valid
b_ready_i  in  1  write response ready
b_id_o  out  IdWidth  echoed AW ID
b_resp_o  out  2  00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR
ar_valid_i  in  1  read address valid
ar_ready_o  out  1  read address ready
ar_id_i  in  IdWidth  read ID
ar_addr_i  in  AddrWidth  read start byte address
ar_len_i  in  8  beats-1
ar_burst_i  in  2  burst type
r_valid_o  out  1  read data valid
r_ready_i  in  1  read data ready
r_id_o  out  IdWidth  echoed AR ID
r_data_o  out  DataWidth  read data
r_resp_o  out  2  read response
r_last_o  out  1  last read beat
aw_lock_i / ar_lock_i  in  1 each  exclusive access (only with AXI_MEM_EXCL_EN)

Behaviour:
- Reset: async on rst_ni low. FSM=IDLE, all valid/ready outputs 0, b_id_o/r_id_o/r_data_o/resp 0, r_last_o 0, rr_last=READ. SRAM contents are not reset.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE: aw_ready_o/ar_ready_o asserted combinationally only for the granted channel. If both valid, grant the channel not served last (round-robin). Accept-cycle latches id, word index, len, burst, error code. IDLE->WDATA on AW handshake; IDLE->RDATA on AR handshake.
- Word index = addr[log2(MemWords)+log2(DataWidth/8)-1 : log2(DataWidth/8)]. Low byte-offset bits are ignored; beats are always full width.
- Error code, decided at accept: addr >= MemWords*DataWidth/8 -> DECERR. Otherwise WRAP burst or aw_atop_i != 0 -> SLVERR. Otherwise OKAY. DECERR takes precedence over SLVERR.
- WDATA: w_ready_o=1. Each handshake writes w_data_i bytes selected by w_strb_i to SRAM[idx], but only if the error code is OKAY. INCR: idx+1 per beat, wrapping modulo MemWords. FIXED: idx is held. The state exits on the w_last_i handshake regardless of beat count. A beat-count mismatch sets SLVERR, and writes already performed are kept. Then go to WRESP.
- WRESP: b_valid_o=1 with latched id and resp. Held stable until b_ready_i. Return to IDLE in the handshake cycle.
- RDATA: one SRAM read per beat. The first r_valid_o is asserted the cycle after the AR handshake, which is 1-cycle latency. r_data_o/r_resp_o/r_last_o stay stable while r_valid_o && !r_ready_i. On a handshake the next beat is presented in the following cycle, so there is no bubble at full throughput. r_last_o=1 on beat len. If the error code is not OKAY, r_data_o=0. Return to IDLE after the last handshake.
- No new AW/AR is accepted until the current transaction fully completes.

Optional Feature:
AXI_MEM_EXCL_EN:
- Defined: adds aw_lock_i/ar_lock_i and a single reservation {valid, id, word idx}.
- An exclusive read with OKAY sets the reservation and returns EXOKAY.
- An exclusive write whose id and start idx match a valid reservation performs the write, returns EXOKAY and clears the reservation. If they do not match, the write is suppressed and the response is OKAY.
- Any non-exclusive write to the reserved idx clears the reservation.
- Undefined: no lock ports, no reservation logic, EXOKAY is never produced.

Test Plan:
- AW{id=3,addr=0x10,len=3,INCR}, 4 W beats strb=0xFF data=A..D, then AR same -> B{id=3,OKAY}; R beats A,B,C,D with r_last only on beat 4 and r_id=3.
- Write 0x1122334455667788 with strb=0x0F to addr 0x0 pre-filled with all ones -> read returns 0xFFFFFFFF55667788.
- AR addr=0x2000 (MemWords=1024) len=1 -> 2 beats, resp=DECERR, data=0. AW addr=0x2000 -> writes dropped, B=DECERR.
- AW with atop=0x20 and 1 W beat -> B=SLVERR, memory unchanged. WRAP AR -> SLVERR.
- aw_valid and ar_valid both asserted in IDLE on consecutive transactions -> grants alternate. Holding r_ready_i=0 for 5 cycles keeps R outputs stable. Deasserting rst_ni mid-burst -> all valids 0 in the same cycle.
- With AXI_MEM_EXCL_EN: excl AR id=1 addr=0x40 -> EXOKAY; excl AW id=1 addr=0x40 -> EXOKAY, written. Repeating the excl AW -> OKAY, not written.
